// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: a Moore main FSM that sequences each instruction
// through fetch/decode/execute/memory/writeback, plus a combinational ALU decoder.
//
// Ports:
//   clk, reset      - clock; asynchronous active-high reset forcing FETCH
//   op, funct       - instr[31:26] and instr[5:0] from the instruction register
//   zero            - ALU zero flag, consumed in BEQEX
//   MemWrite, IRWrite, RegWrite, PCEn - datapath write/load enables
//   IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc - datapath mux selects
//   ALUControl      - ALU operation code
//   state           - current FSM state (debug / observation)
module mips_multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       PCEn,
   output logic       IorD,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUControl,
   output logic [3:0] state
);

   localparam int unsigned STATE_W = 4;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [STATE_W-1:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   state_t     cur_state;
   state_t     nxt_state;

   logic       pc_write;
   logic       branch;
   logic [1:0] alu_op;
   logic       mem_write_s;
   logic       ir_write_s;
   logic       reg_write_s;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur_state <= FETCH;
      else       cur_state <= nxt_state;
   end

   // Next-state logic; unreachable codes fall back to FETCH
   always_comb begin
      nxt_state = FETCH;
      case (cur_state)
         FETCH:   nxt_state = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: nxt_state = MEMADR;
               OP_RTYPE:     nxt_state = RTYPEEX;
               OP_BEQ:       nxt_state = BEQEX;
               OP_ADDI:      nxt_state = ADDIEX;
               OP_J:         nxt_state = JEX;
               default:      nxt_state = FETCH;
            endcase
         end
         MEMADR: begin
            if (op == OP_LW)      nxt_state = MEMRD;
            else if (op == OP_SW) nxt_state = MEMWR;
            else                  nxt_state = FETCH;
         end
         MEMRD:   nxt_state = MEMWB;
         RTYPEEX: nxt_state = RTYPEWB;
         ADDIEX:  nxt_state = ADDIWB;
         default: nxt_state = FETCH;
      endcase
   end

   // Moore output decode
   always_comb begin
      mem_write_s = 1'b0;
      ir_write_s  = 1'b0;
      reg_write_s = 1'b0;
      pc_write    = 1'b0;
      branch      = 1'b0;
      IorD        = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSrc       = 2'b00;
      alu_op      = ALUOP_ADD;
      case (cur_state)
         FETCH: begin
            ALUSrcB    = 2'b01;
            ir_write_s = 1'b1;
            pc_write   = 1'b1;
         end
         DECODE:  ALUSrcB = 2'b11;
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMRD:   IorD = 1'b1;
         MEMWB: begin
            MemtoReg    = 1'b1;
            reg_write_s = 1'b1;
         end
         MEMWR: begin
            IorD        = 1'b1;
            mem_write_s = 1'b1;
         end
         RTYPEEX: begin
            ALUSrcA = 1'b1;
            alu_op  = ALUOP_FUNCT;
         end
         RTYPEWB: begin
            RegDst      = 1'b1;
            reg_write_s = 1'b1;
         end
         BEQEX: begin
            ALUSrcA = 1'b1;
            alu_op  = ALUOP_SUB;
            PCSrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         ADDIWB:  reg_write_s = 1'b1;
         JEX: begin
            PCSrc    = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU decoder
   always_comb begin
      ALUControl = 3'b010;
      case (alu_op)
         ALUOP_ADD: ALUControl = 3'b010;
         ALUOP_SUB: ALUControl = 3'b110;
         ALUOP_FUNCT: begin
            case (funct)
               6'b100000: ALUControl = 3'b010;
               6'b100010: ALUControl = 3'b110;
               6'b100100: ALUControl = 3'b000;
               6'b100101: ALUControl = 3'b001;
               6'b101010: ALUControl = 3'b111;
               default:   ALUControl = 3'b010;
            endcase
         end
         default:   ALUControl = 3'b010;
      endcase
   end

   // Enables are masked by reset directly so an aborted instruction cannot
   // write anything in the cycle reset rises.
   assign MemWrite = mem_write_s & ~reset;
   assign IRWrite  = ir_write_s  & ~reset;
   assign RegWrite = reg_write_s & ~reset;
   assign PCEn     = (pc_write | (branch & zero)) & ~reset;
   assign state    = cur_state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
`timescale 1ns/100ps
module tb_mips_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       MemWrite, IRWrite, RegWrite, PCEn;
   logic       IorD, RegDst, MemtoReg, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;

   int n_cmp = 0;
   int n_err = 0;

   mips_multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .PCEn       (PCEn),
      .IorD       (IorD),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .PCSrc      (PCSrc),
      .ALUControl (ALUControl),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and sample away from the rising edge
   task automatic nx();
      @(negedge clk);
   endtask

   // {MemWrite, IRWrite, RegWrite, PCEn}
   function automatic logic [3:0] enables();
      return {MemWrite, IRWrite, RegWrite, PCEn};
   endfunction

   initial begin
      reset = 1'b1;
      op    = 6'b000000;
      funct = 6'b100000;
      zero  = 1'b0;
      #3;
      chk("reset_state", state, 4'd0);
      chk("reset_enables", enables(), 4'b0000);
      chk("reset_alusrcb", {2'b00, ALUSrcB}, 4'b0001);

      // release reset while clock is low; FETCH enables show at once
      nx();
      reset = 1'b0;
      op    = 6'b100011;  // lw
      #1;
      chk("fetch_state", state, 4'd0);
      chk("fetch_enables", enables(), 4'b0101);
      chk("fetch_alucontrol", {1'b0, ALUControl}, 4'b0010);

      // lw: 0,1,2,3,4,0
      nx(); chk("lw_s1", state, 4'd1);
            chk("lw_decode_alusrcb", {2'b00, ALUSrcB}, 4'b0011);
            chk("lw_decode_enables", enables(), 4'b0000);
      nx(); chk("lw_s2", state, 4'd2);
            chk("lw_memadr_alusrcb", {2'b00, ALUSrcB}, 4'b0010);
            chk("lw_memadr_alusrca", {3'b000, ALUSrcA}, 4'b0001);
            chk("lw_memadr_iord", {3'b000, IorD}, 4'b0000);
      nx(); chk("lw_s3", state, 4'd3);
            chk("lw_memrd_iord", {3'b000, IorD}, 4'b0001);
            chk("lw_memrd_enables", enables(), 4'b0000);
      nx(); chk("lw_s4", state, 4'd4);
            chk("lw_memwb_memtoreg", {3'b000, MemtoReg}, 4'b0001);
            chk("lw_memwb_enables", enables(), 4'b0010);
            chk("lw_memwb_regdst", {3'b000, RegDst}, 4'b0000);
      nx(); chk("lw_back_fetch", state, 4'd0);
            chk("lw_fetch_memtoreg", {3'b000, MemtoReg}, 4'b0000);

      // sw: 0,1,2,5,0
      op = 6'b101011;
      nx(); chk("sw_s1", state, 4'd1);
      nx(); chk("sw_s2", state, 4'd2);
            chk("sw_memadr_enables", enables(), 4'b0000);
      nx(); chk("sw_s5", state, 4'd5);
            chk("sw_memwr_enables", enables(), 4'b1000);
            chk("sw_memwr_iord", {3'b000, IorD}, 4'b0001);
      nx(); chk("sw_back_fetch", state, 4'd0);
            chk("sw_fetch_memwrite", {3'b000, MemWrite}, 4'b0000);

      // R-type slt: 0,1,6,7,0
      op = 6'b000000; funct = 6'b101010;
      nx(); chk("slt_s1", state, 4'd1);
      nx(); chk("slt_s6", state, 4'd6);
            chk("slt_alucontrol", {1'b0, ALUControl}, 4'b0111);
            chk("slt_alusrcb", {2'b00, ALUSrcB}, 4'b0000);
            chk("slt_alusrca", {3'b000, ALUSrcA}, 4'b0001);
      nx(); chk("slt_s7", state, 4'd7);
            chk("slt_regdst", {3'b000, RegDst}, 4'b0001);
            chk("slt_wb_enables", enables(), 4'b0010);
      nx(); chk("slt_back_fetch", state, 4'd0);

      // R-type and
      funct = 6'b100100;
      nx(); chk("and_s1", state, 4'd1);
      nx(); chk("and_s6", state, 4'd6);
            chk("and_alucontrol", {1'b0, ALUControl}, 4'b0000);
      funct = 6'b100101;
      #1;   chk("or_alucontrol", {1'b0, ALUControl}, 4'b0001);
      funct = 6'b111111;
      #1;   chk("unk_funct_alucontrol", {1'b0, ALUControl}, 4'b0010);
      nx(); chk("and_s7", state, 4'd7);
      nx(); chk("and_back_fetch", state, 4'd0);

      // beq taken
      op = 6'b000100; zero = 1'b1;
      nx(); chk("beqt_s1", state, 4'd1);
            chk("beqt_decode_pcen", {3'b000, PCEn}, 4'b0000);
      nx(); chk("beqt_s8", state, 4'd8);
            chk("beqt_pcen", {3'b000, PCEn}, 4'b0001);
            chk("beqt_pcsrc", {2'b00, PCSrc}, 4'b0001);
            chk("beqt_alucontrol", {1'b0, ALUControl}, 4'b0110);
      nx(); chk("beqt_back_fetch", state, 4'd0);

      // beq not taken
      zero = 1'b0;
      nx(); chk("beqn_s1", state, 4'd1);
      nx(); chk("beqn_s8", state, 4'd8);
            chk("beqn_pcen", {3'b000, PCEn}, 4'b0000);
      nx(); chk("beqn_back_fetch", state, 4'd0);

      // j: 0,1,11,0
      op = 6'b000010;
      nx(); chk("j_s1", state, 4'd1);
      nx(); chk("j_s11", state, 4'd11);
            chk("j_pcsrc", {2'b00, PCSrc}, 4'b0010);
            chk("j_enables", enables(), 4'b0001);
      nx(); chk("j_back_fetch", state, 4'd0);

      // illegal opcode: 0,1,0
      op = 6'b111111;
      nx(); chk("ill_s1", state, 4'd1);
            chk("ill_decode_enables", enables(), 4'b0000);
      nx(); chk("ill_back_fetch", state, 4'd0);
            chk("ill_fetch_enables", enables(), 4'b0101);

      // addi: 0,1,9,10,0
      op = 6'b001000;
      nx(); chk("addi_s1", state, 4'd1);
      nx(); chk("addi_s9", state, 4'd9);
            chk("addi_alusrcb", {2'b00, ALUSrcB}, 4'b0010);
            chk("addi_alucontrol", {1'b0, ALUControl}, 4'b0010);
      nx(); chk("addi_s10", state, 4'd10);
            chk("addi_wb_enables", enables(), 4'b0010);
            chk("addi_regdst", {3'b000, RegDst}, 4'b0000);
      nx(); chk("addi_back_fetch", state, 4'd0);

      // sw aborted by reset in MEMWR
      op = 6'b101011;
      nx(); chk("swr_s1", state, 4'd1);
      nx(); chk("swr_s2", state, 4'd2);
      nx(); chk("swr_s5", state, 4'd5);
            chk("swr_memwrite_pre", {3'b000, MemWrite}, 4'b0001);
      #1;   reset = 1'b1;
      #1;   chk("swr_reset_state", state, 4'd0);
            chk("swr_reset_enables", enables(), 4'b0000);
            chk("swr_reset_alusrcb", {2'b00, ALUSrcB}, 4'b0001);
      nx(); chk("swr_held_state", state, 4'd0);
            chk("swr_held_enables", enables(), 4'b0000);
      reset = 1'b0;
      op    = 6'b000100;
      #1;   chk("swr_release_enables", enables(), 4'b0101);
            chk("swr_release_state", state, 4'd0);
      nx(); chk("swr_next_decode", state, 4'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
